// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_control_fsm_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic             Zero;
   logic             MemReady;
   logic             MemReq;
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       ImmSrc;
   logic             Illegal;
   logic [CNT_W-1:0] InstRet;
   logic [3:0]       State;

   modport master (
      input  op, Zero, MemReady,
      output MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstRet, State
   );

   modport slave (
      output op, Zero, MemReady,
      input  MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstRet, State
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: Moore datapath controls per state, 3-5 cycles per instruction.
// Memory wait-states stall FETCH/MEMREAD/MEMWRITE one cycle per MemReady=0; rst forces all outputs to 0.
module multicycle_control_fsm #(
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_control_fsm_if.master bus
);
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] inst_ret_q, inst_ret_d;

   logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write;
   logic       illegal, valid, retire;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         inst_ret_q <= '0;
      end else begin
         state_q    <= state_d;
         inst_ret_q <= inst_ret_d;
      end
   end

   always_comb begin
      imm_src = 2'b00;
      case (bus.op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      valid      = 1'b1;
      retire     = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (bus.MemReady) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // PC-relative target computed here so BEQ can take it from ALUOut.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (bus.MemReady) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_write  = bus.Zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            valid   = 1'b0;
            state_d = S_FETCH;
         end
      endcase
      inst_ret_d = retire ? inst_ret_q + CNT_W'(1) : inst_ret_q;
   end

   // Reset overrides every output combinationally so an aborted store never strobes.
   assign bus.MemReq    = !rst && mem_req;
   assign bus.PCWrite   = !rst && pc_write;
   assign bus.AdrSrc    = !rst && adr_src;
   assign bus.MemWrite  = !rst && mem_write;
   assign bus.IRWrite   = !rst && ir_write;
   assign bus.RegWrite  = !rst && reg_write;
   assign bus.Illegal   = !rst && illegal;
   assign bus.ResultSrc = rst ? 2'b00 : result_src;
   assign bus.ALUSrcA   = rst ? 2'b00 : alu_src_a;
   assign bus.ALUSrcB   = rst ? 2'b00 : alu_src_b;
   assign bus.ALUOp     = rst ? 2'b00 : alu_op;
   assign bus.ImmSrc    = (rst || !valid) ? 2'b00 : imm_src;
   assign bus.InstRet   = rst ? '0 : inst_ret_q;
   assign bus.State     = rst ? 4'd0 : 4'(state_q);
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level path model plus per-cycle output checks.
module tb_multicycle_control_fsm;
   localparam int CW = 4;
   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1110011;

   typedef struct packed {
      logic       memreq, pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
      logic [1:0] resultsrc, alusrca, alusrcb, aluop, immsrc;
      logic [3:0] cnt;
      logic [3:0] state;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_control_fsm_if #(.CNT_W(CW)) bus();
   multicycle_control_fsm #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   total = 0;
   int   bad = 0;
   logic chk_en = 1'b0;
   logic capture = 1'b0;
   int   exp_st = 0;
   int   cnt_m = 0;
   logic retire_pend = 1'b0;
   logic prev_rst = 1'b1;
   int   tr_st[$], tr_pcw[$], tr_rw[$], tr_aop[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output rules per architectural step of an instruction.
   function automatic exp_t model(input int st, input logic [6:0] op, input logic z,
                                  input logic mr, input logic r, input int cnt);
      exp_t e;
      e = '0;
      if (r) return e;
      e.state = st[3:0];
      e.cnt   = cnt[3:0];
      if (op == SW) e.immsrc = 2'b01;
      else if (op == BEQ) e.immsrc = 2'b10;
      else if (op == JAL) e.immsrc = 2'b11;
      case (st)
         0:  begin e.memreq = 1; e.alusrcb = 2; e.resultsrc = 2; e.irwrite = mr; e.pcwrite = mr; end
         1:  begin e.alusrca = 1; e.alusrcb = 1; end
         2:  begin e.alusrca = 2; e.alusrcb = 1; end
         3:  begin e.memreq = 1; e.adrsrc = 1; end
         4:  begin e.resultsrc = 1; e.regwrite = 1; end
         5:  begin e.memreq = 1; e.adrsrc = 1; e.memwrite = 1; end
         6:  begin e.alusrca = 2; e.aluop = 2; end
         7:  begin e.regwrite = 1; end
         8:  begin e.alusrca = 2; e.alusrcb = 1; e.aluop = 2; end
         9:  begin e.alusrca = 1; e.alusrcb = 2; e.pcwrite = 1; end
         10: begin e.alusrca = 2; e.aluop = 1; e.pcwrite = z; end
         11: begin e.illegal = 1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         e = model(exp_st, bus.op, bus.Zero, bus.MemReady, rst, cnt_m);
         chk("State", bus.State, e.state);
         chk("InstRet", bus.InstRet, e.cnt);
         chk("MemReq", bus.MemReq, e.memreq);
         chk("PCWrite", bus.PCWrite, e.pcwrite);
         chk("AdrSrc", bus.AdrSrc, e.adrsrc);
         chk("MemWrite", bus.MemWrite, e.memwrite);
         chk("IRWrite", bus.IRWrite, e.irwrite);
         chk("RegWrite", bus.RegWrite, e.regwrite);
         chk("Illegal", bus.Illegal, e.illegal);
         chk("ResultSrc", bus.ResultSrc, e.resultsrc);
         chk("ALUSrcA", bus.ALUSrcA, e.alusrca);
         chk("ALUSrcB", bus.ALUSrcB, e.alusrcb);
         chk("ALUOp", bus.ALUOp, e.aluop);
         chk("ImmSrc", bus.ImmSrc, e.immsrc);
         if (capture) begin
            tr_st.push_back(int'(bus.State));
            tr_pcw.push_back(int'(bus.PCWrite));
            tr_rw.push_back(int'(bus.RegWrite));
            tr_aop.push_back(int'(bus.ALUOp));
         end
      end
   end

   // One clock cycle: st is the step the instruction should be in during this cycle.
   task automatic drive(input int st, input logic [6:0] op, input logic r, input logic mr, input logic z);
      @(posedge clk);
      #1;
      if (prev_rst) cnt_m = 0;
      else if (retire_pend) cnt_m = (cnt_m + 1) % (1 << CW);
      retire_pend = 1'b0;
      prev_rst    = r;
      rst = r; bus.op = op; bus.MemReady = mr; bus.Zero = z; exp_st = st;
      @(negedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wm);
      int path[$];
      case (op)
         LW:      path = '{1, 2, 3, 4};
         SW:      path = '{1, 2, 5};
         RT:      path = '{1, 6, 7};
         IT:      path = '{1, 8, 7};
         JAL:     path = '{1, 9, 7};
         default: path = '{1, 10};
      endcase
      repeat (wf) drive(0, op, 1'b0, 1'b0, z);
      drive(0, op, 1'b0, 1'b1, z);
      foreach (path[i]) begin
         if (path[i] == 3 || path[i] == 5) begin
            repeat (wm) drive(path[i], op, 1'b0, 1'b0, z);
            drive(path[i], op, 1'b0, 1'b1, z);
         end else begin
            drive(path[i], op, 1'b0, 1'($urandom_range(0, 1)), z);
         end
      end
      retire_pend = 1'b1;
   endtask

   task automatic stall_chk(input string name, input int exp_cnt);
      drive(0, RT, 1'b0, 1'b0, 1'b0);
      chk(name, bus.InstRet, exp_cnt);
   endtask

   task automatic check_trace(input string nm, input int n, input int st[8], input int pcw[8],
                              input int rw[8], input int aop[8]);
      chk({nm, "_len"}, tr_st.size(), n);
      for (int i = 0; i < n && i < tr_st.size(); i++) begin
         chk($sformatf("%s_state%0d", nm, i), tr_st[i], st[i]);
         chk($sformatf("%s_pcw%0d", nm, i), tr_pcw[i], pcw[i]);
         chk($sformatf("%s_rw%0d", nm, i), tr_rw[i], rw[i]);
         chk($sformatf("%s_aluop%0d", nm, i), tr_aop[i], aop[i]);
      end
      tr_st.delete(); tr_pcw.delete(); tr_rw.delete(); tr_aop.delete();
   endtask

   initial begin
      rst = 1'b1; bus.op = 7'd0; bus.MemReady = 1'b1; bus.Zero = 1'b0;
      chk_en = 1'b1;

      // Reset, first fetch, lw with two memory wait cycles
      repeat (3) drive(0, 7'd0, 1'b1, 1'b1, 1'b0);
      chk("rst_instret", bus.InstRet, 0);
      chk("rst_memreq", bus.MemReq, 0);
      capture = 1'b1;
      run_instr(LW, 1'b0, 0, 2);
      stall_chk("lw_instret", 1);
      capture = 1'b0;
      check_trace("lw", 8, '{0, 1, 2, 3, 3, 3, 4, 0}, '{1, 0, 0, 0, 0, 0, 0, 0},
                  '{0, 0, 0, 0, 0, 0, 1, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

      // R, I, jal from a fresh counter
      drive(0, 7'd0, 1'b1, 1'b1, 1'b0);
      run_instr(RT, 1'b0, 0, 0);
      capture = 1'b1;
      run_instr(IT, 1'b0, 0, 0);
      run_instr(JAL, 1'b0, 0, 0);
      capture = 1'b0;
      check_trace("i_jal", 8, '{0, 1, 8, 7, 0, 1, 9, 7}, '{1, 0, 0, 0, 1, 0, 1, 0},
                  '{0, 0, 0, 1, 0, 0, 0, 1}, '{0, 0, 2, 0, 0, 0, 0, 0});
      stall_chk("rij_instret", 3);

      // beq taken, then not taken behind a fetch wait
      capture = 1'b1;
      run_instr(BEQ, 1'b1, 0, 0);
      run_instr(BEQ, 1'b0, 1, 0);
      capture = 1'b0;
      check_trace("beq", 7, '{0, 1, 10, 0, 0, 1, 10, 0}, '{1, 0, 1, 0, 1, 0, 0, 0},
                  '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0, 1, 0});
      stall_chk("beq_instret", 5);

      run_instr(SW, 1'b0, 1, 1);
      stall_chk("sw_instret", 6);

      // Reset while a store waits on memory
      drive(0, SW, 1'b0, 1'b1, 1'b0);
      drive(1, SW, 1'b0, 1'b1, 1'b0);
      drive(2, SW, 1'b0, 1'b1, 1'b0);
      drive(5, SW, 1'b0, 1'b0, 1'b0);
      chk("store_wait_memwrite", bus.MemWrite, 1);
      drive(5, SW, 1'b1, 1'b0, 1'b0);
      chk("abort_memwrite", bus.MemWrite, 0);
      drive(0, RT, 1'b0, 1'b1, 1'b0);
      chk("abort_state", bus.State, 0);
      chk("abort_memreq", bus.MemReq, 1);
      chk("abort_instret", bus.InstRet, 0);
      drive(1, RT, 1'b0, 1'b1, 1'b0);
      drive(6, RT, 1'b0, 1'b1, 1'b0);
      drive(7, RT, 1'b0, 1'b1, 1'b0);
      retire_pend = 1'b1;
      for (int k = 0; k < 16; k++) run_instr((k % 2) ? IT : RT, 1'b0, 0, 0);
      stall_chk("wrap_instret", 1);

      // Illegal opcode traps until reset
      drive(0, BAD, 1'b0, 1'b1, 1'b0);
      drive(1, BAD, 1'b0, 1'b1, 1'b0);
      repeat (20) drive(11, BAD, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("trap_illegal", bus.Illegal, 1);
      chk("trap_state", bus.State, 11);
      drive(11, BAD, 1'b1, 1'b1, 1'b0);
      chk("trap_rst_illegal", bus.Illegal, 0);
      drive(0, RT, 1'b0, 1'b0, 1'b0);
      chk("post_trap_state", bus.State, 0);
      chk("post_trap_illegal", bus.Illegal, 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
